// File: rtl/peripheral_dbg_soc_dii_ring_router.sv
// peripheral_dbg_soc_dii_ring_router: DII ring stage that peels packets addressed to id off the ring
// and merges local packets onto ring_out with packet-locked round-robin arbitration.
module peripheral_dbg_soc_dii_ring_router #(
  parameter bit LOCAL_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  logic [15:0] ring_in_data,
  input  logic        ring_in_valid,
  input  logic        ring_in_last,
  output logic        ring_in_ready,
  output logic [15:0] ring_out_data,
  output logic        ring_out_valid,
  output logic        ring_out_last,
  input  logic        ring_out_ready,
  input  logic [15:0] local_in_data,
  input  logic        local_in_valid,
  input  logic        local_in_last,
  output logic        local_in_ready,
  output logic [15:0] local_out_data,
  output logic        local_out_valid,
  output logic        local_out_last,
  input  logic        local_out_ready
);
  typedef enum logic [1:0] {IDLE, TO_LOCAL, TO_RING} demux_t;
  typedef enum logic [1:0] {ARB_IDLE, GNT_FWD, GNT_LOCAL} arb_t;
  demux_t dstate, dnext;
  arb_t astate, anext;
  logic last_local, last_local_next;
  logic route_local, fwd_valid, gnt_fwd, gnt_local, in_xfer, out_xfer;
  always_comb begin
    route_local = dstate == IDLE ? ring_in_data == id : dstate == TO_LOCAL;
    fwd_valid = !rst && ring_in_valid && !route_local;
    // in ARB_IDLE a collision goes to whoever did not win the previous grant
    gnt_fwd = !rst && (astate == GNT_FWD ||
              (astate == ARB_IDLE && fwd_valid && (!local_in_valid || last_local)));
    gnt_local = !rst && (astate == GNT_LOCAL ||
                (astate == ARB_IDLE && local_in_valid && !(fwd_valid && last_local)));
    ring_out_valid = gnt_fwd ? fwd_valid : gnt_local && local_in_valid;
    ring_out_data = gnt_local ? local_in_data : ring_in_data;
    ring_out_last = gnt_local ? local_in_last : ring_in_last;
    ring_in_ready = !rst && (route_local ? local_out_ready : gnt_fwd && ring_out_ready);
    local_in_ready = gnt_local && ring_out_ready;
    local_out_valid = !rst && ring_in_valid && route_local;
    local_out_data = ring_in_data;
    local_out_last = ring_in_last;
    in_xfer = ring_in_valid && ring_in_ready;
    out_xfer = ring_out_valid && ring_out_ready;
    dnext = dstate;
    anext = astate;
    last_local_next = last_local;
    if (in_xfer) dnext = ring_in_last ? IDLE : route_local ? TO_LOCAL : TO_RING;
    if (out_xfer) begin
      anext = ring_out_last ? ARB_IDLE : gnt_local ? GNT_LOCAL : GNT_FWD;
      last_local_next = gnt_local;
    end
  end
  // last_local starts inverted so the first collision goes to the side LOCAL_FIRST names
  always_ff @(posedge clk) begin
    if (rst) begin
      dstate <= IDLE;
      astate <= ARB_IDLE;
      last_local <= !LOCAL_FIRST;
    end else begin
      dstate <= dnext;
      astate <= anext;
      last_local <= last_local_next;
    end
  end
endmodule

// File: tb/tb_peripheral_dbg_soc_dii_ring_router.sv
// tb_peripheral_dbg_soc_dii_ring_router: directed ring-router scenarios plus randomized traffic
// compared every cycle against a packet-level model of routing and ring_out ownership.
module tb_peripheral_dbg_soc_dii_ring_router;
  localparam bit LF = 1'b0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] id = 16'h0005;
  logic [15:0] ring_in_data = '0, ring_out_data, local_in_data = '0, local_out_data;
  logic ring_in_valid = 1'b0, ring_in_last = 1'b0, ring_in_ready;
  logic ring_out_valid, ring_out_last, ring_out_ready = 1'b1;
  logic local_in_valid = 1'b0, local_in_last = 1'b0, local_in_ready;
  logic local_out_valid, local_out_last, local_out_ready = 1'b1;

  peripheral_dbg_soc_dii_ring_router #(.LOCAL_FIRST(LF)) dut (
    .clk(clk), .rst(rst), .id(id),
    .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_last(ring_in_last),
    .ring_in_ready(ring_in_ready),
    .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_last(ring_out_last),
    .ring_out_ready(ring_out_ready),
    .local_in_data(local_in_data), .local_in_valid(local_in_valid), .local_in_last(local_in_last),
    .local_in_ready(local_in_ready),
    .local_out_data(local_out_data), .local_out_valid(local_out_valid), .local_out_last(local_out_last),
    .local_out_ready(local_out_ready)
  );

  always #5 clk = ~clk;

  int cmps = 0;
  int errs = 0;
  bit rnd = 1'b0;
  logic [16:0] rq[$];
  logic [16:0] lq[$];
  int rcnt = 0, lcnt = 0, rbase = 0, lbase = 0, ridx, lidx;
  bit rpop = 1'b0, lpop = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {last, data} flits: header first, then base+1, base+2, ...
  task automatic pkt(input bit ring, input logic [15:0] hdr, input int n, input logic [15:0] base);
    logic [16:0] f;
    for (int i = 0; i < n; i++) begin
      f = {i == n - 1, i == 0 ? hdr : base + 16'(i)};
      if (ring) rq.push_back(f);
      else lq.push_back(f);
    end
  endtask

  // sources: present queue heads, advance on accepted transfers
  always @(posedge clk) begin
    if (rpop) rcnt++;
    if (lpop) lcnt++;
    #2;
    ridx = rcnt + rbase;
    lidx = lcnt + lbase;
    ring_in_valid = ridx < rq.size() && (!rnd || $urandom_range(3) != 0);
    {ring_in_last, ring_in_data} = ridx < rq.size() ? rq[ridx] : 17'h0;
    local_in_valid = lidx < lq.size() && (!rnd || $urandom_range(3) != 0);
    {local_in_last, local_in_data} = lidx < lq.size() ? lq[lidx] : 17'h0;
  end

  // packet-level model: position in the current ring_in packet and its route,
  // current owner of ring_out (0 none, 1 forward, 2 local) and who is owed the next collision
  int m_idx = 0, m_owner = 0, m_win;
  bit m_local = 1'b0, m_pref_local = LF;
  bit m_hdr, m_tl, m_fr, m_lr, e_rov, e_rol, e_lov, e_rir, e_lir;
  logic [15:0] e_rod;
  always @(negedge clk) begin
    m_hdr = m_idx == 0;
    m_tl = m_hdr ? ring_in_data == id : m_local;
    m_fr = !rst && ring_in_valid && !m_tl;
    m_lr = !rst && local_in_valid;
    if (rst) m_win = 0;
    else if (m_owner != 0) m_win = m_owner;
    else if (m_fr && m_lr) m_win = m_pref_local ? 2 : 1;
    else m_win = m_fr ? 1 : m_lr ? 2 : 0;
    e_rov = m_win == 1 ? m_fr : m_win == 2 ? m_lr : 1'b0;
    e_rod = m_win == 2 ? local_in_data : ring_in_data;
    e_rol = m_win == 2 ? local_in_last : ring_in_last;
    e_lov = !rst && ring_in_valid && m_tl;
    e_rir = !rst && (m_tl ? local_out_ready : m_win == 1 && ring_out_ready);
    e_lir = !rst && m_win == 2 && ring_out_ready;
    chk("m_ring_out_valid", 16'(ring_out_valid), 16'(e_rov));
    chk("m_local_out_valid", 16'(local_out_valid), 16'(e_lov));
    chk("m_ring_in_ready", 16'(ring_in_ready), 16'(e_rir));
    chk("m_local_in_ready", 16'(local_in_ready), 16'(e_lir));
    if (e_rov) begin
      chk("m_ring_out_data", ring_out_data, e_rod);
      chk("m_ring_out_last", 16'(ring_out_last), 16'(e_rol));
    end
    if (e_lov) begin
      chk("m_local_out_data", local_out_data, ring_in_data);
      chk("m_local_out_last", 16'(local_out_last), 16'(ring_in_last));
    end
    rpop = ring_in_valid && ring_in_ready;
    lpop = local_in_valid && local_in_ready;
    if (rst) begin
      m_idx = 0;
      m_owner = 0;
      m_pref_local = LF;
    end else begin
      if (ring_in_valid && e_rir) begin
        if (m_hdr) m_local = m_tl;
        m_idx = ring_in_last ? 0 : m_idx + 1;
      end
      if (e_rov && ring_out_ready) begin
        m_pref_local = m_win == 1;
        m_owner = e_rol ? 0 : m_win;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ring_out_valid", 16'(ring_out_valid), 16'h0);
    chk("rst_local_out_valid", 16'(local_out_valid), 16'h0);
    chk("rst_ring_in_ready", 16'(ring_in_ready), 16'h0);
    chk("rst_local_in_ready", 16'(local_in_ready), 16'h0);
    // 3-flit packet for this router
    @(posedge clk); #1; rst = 1'b0; pkt(1, 16'h0005, 3, 16'hA0);
    @(negedge clk);
    chk("a0_lo_valid", 16'(local_out_valid), 16'h1);
    chk("a0_lo_data", local_out_data, 16'h0005);
    chk("a0_ro_valid", 16'(ring_out_valid), 16'h0);
    chk("a0_ri_ready", 16'(ring_in_ready), 16'h1);
    @(negedge clk);
    chk("a1_lo_data", local_out_data, 16'h00A1);
    chk("a1_ro_valid", 16'(ring_out_valid), 16'h0);
    @(negedge clk);
    chk("a2_lo_data", local_out_data, 16'h00A2);
    chk("a2_lo_last", 16'(local_out_last), 16'h1);
    @(negedge clk);
    chk("a3_lo_valid", 16'(local_out_valid), 16'h0);
    // 2-flit forward packet, ring_out stalled for one cycle
    @(posedge clk); #1; ring_out_ready = 1'b0; pkt(1, 16'h0007, 2, 16'hB0);
    @(negedge clk);
    chk("b0_ro_valid", 16'(ring_out_valid), 16'h1);
    chk("b0_ro_data", ring_out_data, 16'h0007);
    chk("b0_ri_ready", 16'(ring_in_ready), 16'h0);
    chk("b0_lo_valid", 16'(local_out_valid), 16'h0);
    @(posedge clk); #1; ring_out_ready = 1'b1;
    @(negedge clk);
    chk("b1_ro_data", ring_out_data, 16'h0007);
    chk("b1_ri_ready", 16'(ring_in_ready), 16'h1);
    @(negedge clk);
    chk("b2_ro_data", ring_out_data, 16'h00B1);
    chk("b2_ro_last", 16'(ring_out_last), 16'h1);
    @(negedge clk);
    chk("b3_ro_valid", 16'(ring_out_valid), 16'h0);
    // collision after reset: forward first, then local wins the repeat collision
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    pkt(1, 16'h0009, 3, 16'h90); pkt(1, 16'h0009, 2, 16'h9A); pkt(0, 16'h0033, 2, 16'h30);
    @(negedge clk);
    chk("c0_ro_data", ring_out_data, 16'h0009);
    chk("c0_li_ready", 16'(local_in_ready), 16'h0);
    @(negedge clk);
    chk("c1_ro_data", ring_out_data, 16'h0091);
    @(negedge clk);
    chk("c2_ro_data", ring_out_data, 16'h0092);
    chk("c2_li_ready", 16'(local_in_ready), 16'h0);
    @(negedge clk);
    chk("c3_ro_data", ring_out_data, 16'h0033);
    chk("c3_li_ready", 16'(local_in_ready), 16'h1);
    chk("c3_ri_ready", 16'(ring_in_ready), 16'h0);
    @(negedge clk);
    chk("c4_ro_data", ring_out_data, 16'h0031);
    chk("c4_ri_ready", 16'(ring_in_ready), 16'h0);
    @(negedge clk);
    chk("c5_ro_data", ring_out_data, 16'h0009);
    chk("c5_ri_ready", 16'(ring_in_ready), 16'h1);
    @(negedge clk);
    chk("c6_ro_data", ring_out_data, 16'h009B);
    @(negedge clk);
    chk("c7_ro_valid", 16'(ring_out_valid), 16'h0);
    // stalled local_out blocks the following ring-bound packet
    @(posedge clk); #1; local_out_ready = 1'b0;
    pkt(1, 16'h0005, 3, 16'h50); pkt(1, 16'h0007, 2, 16'h70);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("d_ri_ready_stall", 16'(ring_in_ready), 16'h0);
      chk("d_lo_data_stall", local_out_data, 16'h0005);
      chk("d_ro_valid_stall", 16'(ring_out_valid), 16'h0);
    end
    @(posedge clk); #1; local_out_ready = 1'b1;
    @(negedge clk);
    chk("d5_lo_data", local_out_data, 16'h0005);
    chk("d5_ri_ready", 16'(ring_in_ready), 16'h1);
    @(negedge clk);
    chk("d6_lo_data", local_out_data, 16'h0051);
    @(negedge clk);
    chk("d7_lo_data", local_out_data, 16'h0052);
    @(negedge clk);
    chk("d8_ro_data", ring_out_data, 16'h0007);
    chk("d8_lo_valid", 16'(local_out_valid), 16'h0);
    @(negedge clk);
    chk("d9_ro_data", ring_out_data, 16'h0071);
    // single-flit local packet, next header routed fresh
    @(posedge clk); #1; pkt(1, 16'h0005, 1, 16'h0); pkt(1, 16'h0007, 2, 16'hE0);
    @(negedge clk);
    chk("e0_lo_valid", 16'(local_out_valid), 16'h1);
    chk("e0_lo_last", 16'(local_out_last), 16'h1);
    chk("e0_ro_valid", 16'(ring_out_valid), 16'h0);
    @(negedge clk);
    chk("e1_lo_valid", 16'(local_out_valid), 16'h0);
    chk("e1_ro_data", ring_out_data, 16'h0007);
    @(negedge clk);
    chk("e2_ro_data", ring_out_data, 16'h00E1);
    // reset in the middle of a 4-flit forward packet
    @(posedge clk); #1; pkt(1, 16'h0007, 4, 16'hF0);
    @(negedge clk);
    chk("f0_ro_data", ring_out_data, 16'h0007);
    @(negedge clk);
    chk("f1_ro_data", ring_out_data, 16'h00F1);
    @(posedge clk); #1; rst = 1'b1; pkt(0, 16'h0066, 1, 16'h0);
    @(negedge clk);
    chk("f_rst_ro_valid", 16'(ring_out_valid), 16'h0);
    chk("f_rst_ri_ready", 16'(ring_in_ready), 16'h0);
    chk("f_rst_li_ready", 16'(local_in_ready), 16'h0);
    chk("f_rst_lo_valid", 16'(local_out_valid), 16'h0);
    @(posedge clk); #1; rst = 1'b0; rbase += 2; pkt(1, 16'h0005, 1, 16'h0);
    @(negedge clk);
    chk("f_after_lo_valid", 16'(local_out_valid), 16'h1);
    chk("f_after_lo_data", local_out_data, 16'h0005);
    chk("f_after_ro_data", ring_out_data, 16'h0066);
    chk("f_after_li_ready", 16'(local_in_ready), 16'h1);
    // randomized traffic, backpressure and occasional resets
    rnd = 1'b1;
    repeat (4000) begin
      @(posedge clk); #1;
      rst = $urandom_range(249) == 0;
      ring_out_ready = $urandom_range(3) != 0;
      local_out_ready = $urandom_range(3) != 0;
      if (rq.size() - (rcnt + rbase) < 4)
        pkt(1, $urandom_range(1) != 0 ? id : 16'($urandom), int'($urandom_range(4, 1)), 16'($urandom));
      if (lq.size() - (lcnt + lbase) < 4)
        pkt(0, 16'($urandom), int'($urandom_range(4, 1)), 16'($urandom));
    end
    @(posedge clk); #1; rst = 1'b0; ring_out_ready = 1'b1; local_out_ready = 1'b1;
    repeat (60) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/peripheral_dbg_soc_dii_ring_router.md
PERIPHERAL_DBG_SOC_DII_RING_ROUTER -- requirements
Module: peripheral_dbg_soc_dii_ring_router

Interface
REQ-001 SHALL have parameter: LOCAL_FIRST, 0, arbitration winner on the first simultaneous request after reset (0 = forward path, 1 = local).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: id  input  16  DII address of this router's local module; quasi-static.
REQ-006 SHALL have port: ring_in  input  dii_flit  flits from upstream, e.g. the host interface's dii_out; dii_flit is data[15:0], valid, last.
REQ-007 SHALL have port: ring_in_ready  output  1  ring_in accept.
REQ-008 SHALL have port: ring_out  output  dii_flit  flits to the next ring stage.
REQ-009 SHALL have port: ring_out_ready  input  1  ring_out accept.
REQ-010 SHALL have port: local_in  input  dii_flit  packets from the local module.
REQ-011 SHALL have port: local_in_ready  output  1  local_in accept.
REQ-012 SHALL have port: local_out  output  dii_flit  packets addressed to id.
REQ-013 SHALL have port: local_out_ready  input  1  local_out accept.

Function
REQ-014 SHALL define a transfer on any channel as valid & ready high at a rising clk edge; flits are never dropped, duplicated or reordered within a packet.
REQ-015 SHALL treat the first flit of every packet as the header, with data[15:0] as destination address.
REQ-016 SHALL implement the ingress demux FSM with states IDLE, TO_LOCAL and TO_RING; reset state is IDLE.
REQ-017 In IDLE with ring_in.valid, SHALL route the header combinationally: dest == id goes to local_out, otherwise to the forward path, in the same cycle with no bubble.
REQ-018 SHALL move to TO_LOCAL or TO_RING when a header transfers with last=0, and stay in IDLE when the header transfers with last=1.
REQ-019 In TO_LOCAL or TO_RING, SHALL steer every flit to the held route and return to IDLE on the transfer of the flit with last=1.
REQ-020 SHALL make ring_in_ready equal to the selected target's ready: local_out_ready for the local route, or forward-path grant & ring_out_ready for the ring route.
REQ-021 SHALL hold local_out.valid = ring_in.valid only while routed local, else 0; local_out.data and local_out.last mirror ring_in.
REQ-022 SHALL arbitrate ring_out between the forward path and local_in with FSM states ARB_IDLE, GNT_FWD and GNT_LOCAL; reset state is ARB_IDLE.
REQ-023 In ARB_IDLE, SHALL grant combinationally in the same cycle: a single requester wins; when both request, the one not granted last wins (round-robin); before any grant the winner is set by LOCAL_FIRST.
REQ-024 SHALL lock the grant from the first transferred flit until the last=1 flit transfers, then return to ARB_IDLE; packets on ring_out never interleave.
REQ-025 SHALL not stall the arbiter FSM for single-flit packets: a grant with last=1 transferring in ARB_IDLE updates the last-granted pointer and stays in ARB_IDLE.
REQ-026 SHALL make ring_out a pure combinational copy of the granted source, and keep ring_out.valid at 0 when nothing is granted.
REQ-027 SHALL keep local_in_ready at 0 unless local holds the grant.
REQ-028 SHALL accept head-of-line blocking: a stalled local_out blocks all following ring_in packets.
REQ-029 SHALL not lose the granted packet when valid drops mid-packet; state holds until the last flit transfers.

Reset
REQ-030 While rst is high, SHALL force both FSMs to idle, set the last-granted pointer per LOCAL_FIRST, and hold all output valids and readies at 0.
REQ-031 SHALL resume after reset mid-packet with the next ring_in and local_in flits treated as headers; partial packets are the sender's responsibility.

Verification
REQ-032 SHALL cover: id=0x0005, ring_in 3-flit packet with header 0x0005 -> 3 flits on local_out in 3 cycles, ring_out.valid stays 0.
REQ-033 SHALL cover: header 0x0007, 2-flit packet, LOCAL_FIRST=0 -> identical flits on ring_out in the same cycles, ring_in_ready = ring_out_ready.
REQ-034 SHALL cover: after reset, a 3-flit forward packet and a 2-flit local packet both valid in cycle 0 -> forward flits in cycles 0-2, local in 3-4, no interleave; a repeat of the collision -> local first.
REQ-035 SHALL cover: local_out_ready=0 for 5 cycles during a local-bound packet followed by a ring-bound packet -> ring_in_ready=0 for those cycles, then both packets complete intact.
REQ-036 SHALL cover: single-flit packet with header 0x0005 and last=1 -> one local_out transfer; the next cycle's header is routed fresh.
REQ-037 SHALL cover: rst asserted after flit 2 of a 4-flit forward packet -> all valids and readies 0 during reset; afterwards the next ring_in flit is routed as a header.
